// File: rtl/fml_pkg.sv
// -----------------------------------------------------------------------------
// fml_pkg
// Shared definitions for the FML burst slave and its local RAM.
//   FML_BURST_LEN : beats per burst (fixed 4)
//   FML_DW        : data width of one beat
//   FML_SELW      : number of byte enables per beat
//   FML_BEATW     : width of a beat index inside a burst
//   fml_state_e   : slave protocol state (IDLE / WRITE / READ)
// -----------------------------------------------------------------------------
package fml_pkg;

    localparam int FML_BURST_LEN = 4;
    localparam int FML_DW        = 16;
    localparam int FML_SELW      = 2;
    localparam int FML_BEATW     = $clog2(FML_BURST_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } fml_state_e;

endpackage

// File: rtl/fml_bram_ram.sv
// -----------------------------------------------------------------------------
// fml_bram_ram
// Single-port synchronous RAM, 2^ADDR_W words of FML_DW bits, with one write
// enable per byte lane and a registered read port (data valid one cycle after
// re_i). Write and read are never requested in the same cycle by the slave.
//   clk_i    : clock, rising edge
//   we_i     : byte-lane write enables, bit1 = [15:8], bit0 = [7:0]
//   re_i     : read strobe, rdata_o updates on the next rising edge
//   addr_i   : word address
//   wdata_i  : write data
//   rdata_o  : registered read data
// -----------------------------------------------------------------------------
module fml_bram_ram
    import fml_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                clk_i,
    input  logic [FML_SELW-1:0] we_i,
    input  logic                re_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [FML_DW-1:0]   wdata_i,
    output logic [FML_DW-1:0]   rdata_o
);

    logic [FML_DW-1:0] mem_q [2**ADDR_W];
    logic [FML_DW-1:0] rdata_q;

    // NOTE: the storage array is deliberately left out of any reset so it maps
    // onto block RAM and keeps its contents across a system reset.
    always_ff @(posedge clk_i) begin
        if (we_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
        if (we_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
        if (re_i)    rdata_q             <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fml_bram_slave.sv
// -----------------------------------------------------------------------------
// fml_bram_slave
// FML slave backed by a local RAM. Transfers fixed 4-beat bursts of 16 bits,
// critical word first, wrapping inside the aligned 4-word block.
//   sys_clk   : clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   fml_adr   : byte address (bit0 ignored, [2:1] first beat, [mem_depth:3] block)
//   fml_stb   : request, held with adr/we until fml_ack
//   fml_we    : 1 = write burst, 0 = read burst
//   fml_ack   : one-cycle acceptance, only in IDLE
//   fml_sel   : per-beat byte enables
//   fml_di    : write data beat
//   fml_do    : read data beat, zero outside read beats
// -----------------------------------------------------------------------------
module fml_bram_slave
    import fml_pkg::*;
#(
    parameter int fml_depth = 25,
    parameter int mem_depth = 12
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [fml_depth-1:0] fml_adr,
    input  logic                 fml_stb,
    input  logic                 fml_we,
    output logic                 fml_ack,
    input  logic [FML_SELW-1:0]  fml_sel,
    input  logic [FML_DW-1:0]    fml_di,
    output logic [FML_DW-1:0]    fml_do
);

    localparam int                   BASE_W    = mem_depth - 2;
    localparam logic [FML_BEATW-1:0] LAST_BEAT = FML_BEATW'(FML_BURST_LEN - 1);

    fml_state_e           state_q;
    logic [FML_BEATW-1:0] cnt_q;
    logic [FML_BEATW-1:0] start_q;
    logic [FML_BEATW-1:0] beat_off;
    logic [BASE_W-1:0]    base_q;
    logic                 ready_q;
    logic                 rd_valid_q;

    logic [FML_SELW-1:0]  ram_we;
    logic                 ram_re;
    logic [mem_depth-1:0] ram_addr;
    logic [FML_DW-1:0]    ram_rdata;

    // Address bits above the RAM window and the byte bit are ignored.
    logic unused_adr;
    assign unused_adr = ^{fml_adr[fml_depth-1:mem_depth+1], fml_adr[0]};

    // ready_q keeps ack low during reset and until the first edge after release.
    assign fml_ack  = ready_q && fml_stb && (state_q == IDLE);
    assign beat_off = start_q + cnt_q;

    // NOTE: combinational logic uses blocking assignments with a default for
    // every output first, so no path leaves a signal unassigned (no latch).
    always_comb begin
        ram_we   = '0;
        ram_re   = 1'b0;
        ram_addr = {base_q, beat_off};
        case (state_q)
            IDLE: begin
                // Beat 0 uses the live address in the ack cycle.
                ram_addr = {fml_adr[mem_depth:3], fml_adr[2:1]};
                if (fml_ack) begin
                    ram_we = fml_we ? fml_sel : '0;
                    ram_re = !fml_we;
                end
            end
            WRITE:   ram_we = fml_sel;
            // cnt_q wraps to 0 for the cycle that presents the last read beat.
            READ:    ram_re = (cnt_q != '0);
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            start_q    <= '0;
            base_q     <= '0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            ready_q    <= 1'b1;
            rd_valid_q <= ram_re;
            case (state_q)
                IDLE: begin
                    if (fml_ack) begin
                        base_q  <= fml_adr[mem_depth:3];
                        start_q <= fml_adr[2:1];
                        cnt_q   <= FML_BEATW'(1);
                        state_q <= fml_we ? WRITE : READ;
                    end
                end
                WRITE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_q <= IDLE;
                end
                READ: begin
                    if (cnt_q == '0) state_q <= IDLE;
                    else             cnt_q   <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fml_bram_ram #(
        .ADDR_W (mem_depth)
    ) u_ram (
        .clk_i   (sys_clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (fml_di),
        .rdata_o (ram_rdata)
    );

    assign fml_do = rd_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_fml_bram_slave.sv
// -----------------------------------------------------------------------------
// tb_fml_bram_slave
// Self-checking bench for fml_bram_slave. A word-array model of the RAM is
// updated from the protocol rules (block base, wrapped beat order, byte lanes)
// and every read beat, ack and idle output is compared against it.
// -----------------------------------------------------------------------------
module tb_fml_bram_slave;

    localparam int FD    = 12;
    localparam int MD    = 6;
    localparam int WORDS = 2**MD;
    localparam int ALIAS = 2**(MD+1);

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b1;
    logic [FD-1:0] fml_adr;
    logic          fml_stb;
    logic          fml_we;
    logic          fml_ack;
    logic [1:0]    fml_sel;
    logic [15:0]   fml_di;
    logic [15:0]   fml_do;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model_mem [WORDS];

    always #5 sys_clk = ~sys_clk;

    fml_bram_slave #(
        .fml_depth (FD),
        .mem_depth (MD)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .fml_adr   (fml_adr),
        .fml_stb   (fml_stb),
        .fml_we    (fml_we),
        .fml_ack   (fml_ack),
        .fml_sel   (fml_sel),
        .fml_di    (fml_di),
        .fml_do    (fml_do)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Word index touched by beat 'beat' of a burst at byte address 'adr'.
    function automatic logic [MD-1:0] widx(input logic [FD-1:0] adr, input int beat);
        int b;
        b = int'(adr) % ALIAS;
        return MD'((b / 8) * 4 + ((b / 2) % 4 + beat) % 4);
    endfunction

    task automatic model_write(input logic [FD-1:0] adr, input int beat,
                               input logic [1:0] sel, input logic [15:0] di);
        logic [MD-1:0] w;
        w = widx(adr, beat);
        if (sel[1]) model_mem[w][15:8] = di[15:8];
        if (sel[0]) model_mem[w][7:0]  = di[7:0];
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge sys_clk);
        fml_stb = 1'b0;
        fml_we  = 1'($urandom);
        fml_adr = FD'($urandom);
        #1;
        check({tag, "_idle_ack"}, 32'(fml_ack), 32'd0);
        check({tag, "_idle_do"}, 32'(fml_do), 32'd0);
    endtask

    // Write burst; stb/we/adr are scrambled after ack since they must be ignored.
    task automatic do_write(input string tag, input logic [FD-1:0] adr,
                            input logic [7:0] sels, input logic [63:0] dis);
        @(negedge sys_clk);
        fml_stb = 1'b1;
        fml_we  = 1'b1;
        fml_adr = adr;
        fml_sel = sels[1:0];
        fml_di  = dis[15:0];
        #1;
        check({tag, "_wack"}, 32'(fml_ack), 32'd1);
        check({tag, "_wack_do"}, 32'(fml_do), 32'd0);
        model_write(adr, 0, sels[1:0], dis[15:0]);
        for (int i = 1; i < 4; i++) begin
            @(negedge sys_clk);
            fml_stb = 1'($urandom);
            fml_we  = 1'($urandom);
            fml_adr = FD'($urandom);
            fml_sel = sels[2*i +: 2];
            fml_di  = dis[16*i +: 16];
            #1;
            check($sformatf("%s_wbusy%0d_ack", tag, i), 32'(fml_ack), 32'd0);
            check($sformatf("%s_wbusy%0d_do", tag, i), 32'(fml_do), 32'd0);
            model_write(adr, i, sels[2*i +: 2], dis[16*i +: 16]);
        end
    endtask

    task automatic do_read(input string tag, input logic [FD-1:0] adr);
        logic [15:0] exp_beat [4];
        for (int i = 0; i < 4; i++) exp_beat[i] = model_mem[widx(adr, i)];
        @(negedge sys_clk);
        fml_stb = 1'b1;
        fml_we  = 1'b0;
        fml_adr = adr;
        fml_sel = 2'($urandom);
        fml_di  = 16'($urandom);
        #1;
        check({tag, "_rack"}, 32'(fml_ack), 32'd1);
        check({tag, "_rack_do"}, 32'(fml_do), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            fml_stb = 1'($urandom);
            fml_we  = 1'($urandom);
            fml_adr = FD'($urandom);
            #1;
            check($sformatf("%s_rbeat%0d_ack", tag, i), 32'(fml_ack), 32'd0);
            check($sformatf("%s_rbeat%0d_do", tag, i), 32'(fml_do), 32'(exp_beat[i]));
        end
        idle_cycle({tag, "_tail"});
    endtask

    initial begin
        int            last_ack;
        int            acks;
        int            wstart;
        int            rstart;
        logic          last_we;
        logic          cur_we;
        logic          new_req;
        logic [FD-1:0] wadr;
        logic [15:0]   rexp [4];
        logic [15:0]   exp_do;

        fml_stb = 1'b0;
        fml_we  = 1'b0;
        fml_adr = '0;
        fml_sel = '0;
        fml_di  = '0;

        // Reset: ack stays low even with a pending request, fml_do is zero.
        #2 sys_rst_n = 1'b0;
        @(negedge sys_clk);
        fml_stb = 1'b1;
        #1;
        check("reset_ack", 32'(fml_ack), 32'd0);
        check("reset_do", 32'(fml_do), 32'd0);
        @(negedge sys_clk);
        fml_stb   = 1'b0;
        sys_rst_n = 1'b1;
        idle_cycle("post_reset");

        // Give every word a known value.
        for (int b = 0; b < WORDS / 4; b++)
            do_write("fill", FD'(b * 8), 8'hFF, {$urandom, $urandom});

        // Directed bursts with hand-known data.
        do_write("wr_0x10", FD'('h10), 8'hFF, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
        do_read("rd_0x10", FD'('h10));
        do_read("rd_0x14_wrap", FD'('h14));
        do_write("wr_bytes", FD'('h10), 8'b11_00_01_10, {4{16'hAAAA}});
        do_read("rd_bytes", FD'('h10));

        // Reset asserted during write beat 2.
        @(negedge sys_clk);
        fml_stb = 1'b1;
        fml_we  = 1'b1;
        fml_adr = FD'('h10);
        fml_sel = 2'b11;
        fml_di  = 16'h5555;
        #1;
        check("abort_ack", 32'(fml_ack), 32'd1);
        model_write(FD'('h10), 0, 2'b11, 16'h5555);
        @(negedge sys_clk);
        fml_di = 16'h6666;
        #1;
        model_write(FD'('h10), 1, 2'b11, 16'h6666);
        @(negedge sys_clk);
        fml_di = 16'h7777;
        #1;
        sys_rst_n = 1'b0;
        #1;
        check("abort_rst_ack", 32'(fml_ack), 32'd0);
        check("abort_rst_do", 32'(fml_do), 32'd0);
        @(negedge sys_clk);
        fml_di = 16'h8888;
        #1;
        check("abort_hold_ack", 32'(fml_ack), 32'd0);
        @(negedge sys_clk);
        fml_stb   = 1'b0;
        sys_rst_n = 1'b1;
        do_read("rd_after_abort", FD'('h10));

        // Aliasing above the RAM window, and byte bit ignored.
        do_write("wr_alias", FD'('h18), 8'hFF, {$urandom, $urandom});
        do_read("rd_alias", FD'('h18 + ALIAS + 'h400));
        do_read("rd_alias_b0", FD'('h19));

        // Continuous stb with alternating we: write acks 4 apart, read acks 5.
        last_ack = -1;
        acks     = 0;
        wstart   = -100;
        rstart   = -100;
        cur_we   = 1'b1;
        last_we  = 1'b1;
        wadr     = '0;
        for (int i = 0; i < 4; i++) rexp[i] = '0;
        @(negedge sys_clk);
        fml_stb = 1'b1;
        fml_we  = cur_we;
        fml_adr = FD'($urandom);
        fml_sel = 2'($urandom);
        fml_di  = 16'($urandom);
        for (int cyc = 0; cyc < 64; cyc++) begin
            #1;
            new_req = 1'b0;
            exp_do  = (cyc - rstart >= 1 && cyc - rstart <= 4) ? rexp[cyc - rstart - 1] : 16'h0;
            check($sformatf("cont_do_c%0d", cyc), 32'(fml_do), 32'(exp_do));
            if (cyc - wstart >= 1 && cyc - wstart <= 3)
                model_write(wadr, cyc - wstart, fml_sel, fml_di);
            if (fml_ack) begin
                if (last_ack >= 0)
                    check($sformatf("cont_gap_c%0d", cyc), 32'(cyc - last_ack),
                          last_we ? 32'd4 : 32'd5);
                acks++;
                last_ack = cyc;
                last_we  = cur_we;
                if (cur_we) begin
                    wstart = cyc;
                    wadr   = fml_adr;
                    model_write(wadr, 0, fml_sel, fml_di);
                end else begin
                    rstart = cyc;
                    for (int i = 0; i < 4; i++) rexp[i] = model_mem[widx(fml_adr, i)];
                end
                cur_we  = !cur_we;
                new_req = 1'b1;
            end
            @(negedge sys_clk);
            fml_stb = (cyc + 1 < 59);
            fml_we  = cur_we;
            if (new_req) fml_adr = FD'($urandom);
            fml_sel = 2'($urandom);
            fml_di  = 16'($urandom);
        end
        check("cont_ack_count", 32'(acks), 32'd14);

        // Random traffic against the model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(1, 0) == 1)
                do_write($sformatf("rnd%0d", n), FD'($urandom), 8'($urandom), {$urandom, $urandom});
            else
                do_read($sformatf("rnd%0d", n), FD'($urandom));
            if ($urandom_range(1, 0) == 1) idle_cycle($sformatf("rnd%0d_gap", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fml_bram_slave.md
FML_BRAM_SLAVE -- requirements
Module: fml_bram_slave

Interface
REQ-001 SHALL have parameter fml_depth, default 25: FML byte-address width.
REQ-002 SHALL have parameter mem_depth, default 12: local RAM word-address width (2^mem_depth 16-bit words); fml_depth > mem_depth+1.
REQ-003 SHALL have port sys_clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port fml_adr  input  fml_depth  byte address; bit0 ignored, bits[2:1] first beat, bits[mem_depth:3] burst base.
REQ-006 SHALL have port fml_stb  input  1  request; initiator holds stb/adr/we stable until ack.
REQ-007 SHALL have port fml_we  input  1  1 = write burst, 0 = read burst.
REQ-008 SHALL have port fml_ack  output  1  one-cycle request acceptance.
REQ-009 SHALL have port fml_sel  input  2  per-beat byte enables; bit1 = [15:8], bit0 = [7:0].
REQ-010 SHALL have port fml_di  input  16  write data beat.
REQ-011 SHALL have port fml_do  output  16  read data beat.

Function
REQ-012 SHALL transfer fixed bursts of 4 beats of 16 bits.
REQ-013 SHALL use states IDLE, WRITE, READ; IDLE -> WRITE or READ on the cycle fml_ack is asserted; WRITE/READ -> IDLE after the last beat.
REQ-014 SHALL assert fml_ack for exactly one cycle, only in IDLE with fml_stb=1, combinationally from fml_stb with no wait states.
REQ-015 SHALL never assert fml_ack in WRITE or READ; the earliest next ack is the cycle after the last beat.
REQ-016 SHALL use beat address {fml_adr[mem_depth:3], (fml_adr[2:1]+i) mod 4} for beat i=0..3: critical-word-first, wrapping inside the aligned 4-word block.
REQ-017 SHALL latch the burst base and start beat at ack; later fml_adr changes SHALL be ignored.
REQ-018 Write: SHALL sample fml_di/fml_sel in the ack cycle (beat 0) and the 3 following cycles (beats 1-3).
REQ-019 Write: SHALL write each byte lane only where its fml_sel bit is 1; fml_sel=2'b00 SHALL leave the word unchanged.
REQ-020 Read: SHALL present beats 0-3 on fml_do in cycles ack+1 to ack+4.
REQ-021 SHALL drive fml_do to 16'h0000 in every cycle that is not a read beat.
REQ-022 A read issued the cycle after a write burst ends SHALL return the newly written data (no stale read).
REQ-023 SHALL ignore fml_adr bits above mem_depth, so addresses alias modulo 2^(mem_depth+1) bytes.
REQ-024 SHALL ignore fml_stb, fml_we and fml_adr during WRITE/READ.

Reset
REQ-025 While sys_rst_n=0: state = IDLE, fml_ack = 0, fml_do = 16'h0000, beat counter = 0.
REQ-026 Reset asserted mid-burst SHALL abort the burst immediately; beats already written SHALL remain, remaining beats SHALL be discarded.
REQ-027 RAM contents SHALL NOT be cleared by reset.
REQ-028 The first ack after reset release SHALL occur no earlier than the first rising edge with sys_rst_n=1.

Structure
REQ-029 Shared package fml_pkg SHALL hold FML_BURST_LEN=4, FML_DW=16, FML_SELW=2 and the IDLE/WRITE/READ state enumeration.
REQ-030 Sub-module fml_bram_ram SHALL contain the single-port synchronous RAM with 2 byte-write enables and 1-cycle read latency; the FSM, beat counter and address wrap logic SHALL stay in fml_bram_slave.

Verification
REQ-031 Write adr=0x10, sel=11, di=1111,2222,3333,4444; read adr=0x10 -> ack 1 cycle each; do=1111,2222,3333,4444 in cycles ack+1 to ack+4.
REQ-032 Read adr=0x14 (start beat 2) after REQ-031 data -> do=3333,4444,1111,2222.
REQ-033 Write adr=0x10, sel=10,01,00,11, di=AAAA each beat, then read -> AA11,22AA,3333,AAAA.
REQ-034 stb held high continuously with alternating we -> acks exactly 4 cycles apart for writes and 5 apart for reads, never during a burst; fml_do=0 outside read beats.
REQ-035 sys_rst_n pulled low during write beat 2 -> fml_ack=0 and fml_do=0 immediately; beats 0-1 stored, beats 2-3 keep old values; next request acked normally after release.
REQ-036 Write at adr=0x10, then read at adr=0x10+2^(mem_depth+1) -> same data returned (aliasing).
